as608_responder: RTL

Byte-level AS608 fingerprint-sensor emulator: parses host command packets arriving from a UART receiver and returns AS608 acknowledge packets through a UART transmitter. It is the sensor-side counterpart of our AS608 packet host and is used on the test UART pins. It exercises the host state machine in hardware without a real sensor.

---
 rtl/as608_responder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/as608_responder.sv
// rtl/as608_responder.sv - AS608 fingerprint sensor emulator: parses command packets, returns acknowledge packets
module as608_responder #(
    parameter logic [31:0] ADDR        = 32'hFFFF_FFFF,
    parameter logic [15:0] MAX_LEN     = 16'd32,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        finger_present,
    input  logic [15:0] match_score,
    input  logic [15:0] match_page,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pkt_err,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, H1, A0, A1, A2, A3, PID, LENH, LENL, PAYLOAD, SUMH, SUML, RESP
    } state_t;

    state_t      state, state_n;
    logic [15:0] sum, pay_left, len_w, resp_sum;
    logic [7:0]  lenh, sumh, instr, conf, addr_byte, resp_lenl, tx_byte;
    logic        first, err_n, rx_state, timeout, sum_ok, len_bad;
    logic [23:0] tmo_cnt;
    logic [31:0] data;
    logic [2:0]  n_data;
    logic [4:0]  tx_idx, tx_last, rel;

    assign rx_state = (state != IDLE) && (state != RESP);
    assign timeout  = rx_state && !rx_valid && (tmo_cnt >= TIMEOUT_CYC - 24'd1);
    assign len_w    = {lenh, rx_data};
    assign len_bad  = (len_w < 16'd3) || (len_w > MAX_LEN);
    assign sum_ok   = ({sumh, rx_data} == sum);

    assign tx_valid = (state == RESP);
    assign tx_data  = tx_valid ? tx_byte : 8'h00;
    assign busy     = (state != IDLE);

    // Expected address byte for the current address state, MSB first
    always_comb begin
        case (state)
            A0:      addr_byte = ADDR[31:24];
            A1:      addr_byte = ADDR[23:16];
            A2:      addr_byte = ADDR[15:8];
            default: addr_byte = ADDR[7:0];
        endcase
    end

    // Next-state decode and error pulse request
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end else if (rx_valid) begin
            case (state)
                IDLE:    if (rx_data == 8'hEF) state_n = H1;
                H1: begin
                    if (rx_data == 8'h01)      state_n = A0;
                    else if (rx_data == 8'hEF) state_n = H1;
                    else                       state_n = IDLE;
                end
                A0, A1, A2, A3: begin
                    if (rx_data != addr_byte) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = state_t'(state + 4'd1);
                    end
                end
                PID: begin
                    if (rx_data != 8'h01) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = LENH;
                    end
                end
                LENH:    state_n = LENL;
                LENL: begin
                    if (len_bad) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: if (pay_left == 16'd1) state_n = SUMH;
                SUMH:    state_n = SUML;
                SUML: begin
                    state_n = RESP;
                    err_n   = !sum_ok;
                end
                default: ;
            endcase
        end
        if (state == RESP && tx_ready && tx_idx == tx_last) state_n = IDLE;
    end

    // Response byte selection; unused data bytes are held at zero so they add nothing to the sum
    always_comb begin
        resp_lenl = 8'd3 + {5'd0, n_data};
        resp_sum  = 16'h0007 + {8'h00, resp_lenl} + {8'h00, conf}
                  + {8'h00, data[31:24]} + {8'h00, data[23:16]}
                  + {8'h00, data[15:8]}  + {8'h00, data[7:0]};
        tx_last   = 5'd11 + {2'd0, n_data};
        rel       = tx_idx - 5'd10;
        tx_byte   = 8'h00;
        case (tx_idx)
            5'd0: tx_byte = 8'hEF;
            5'd1: tx_byte = 8'h01;
            5'd2: tx_byte = ADDR[31:24];
            5'd3: tx_byte = ADDR[23:16];
            5'd4: tx_byte = ADDR[15:8];
            5'd5: tx_byte = ADDR[7:0];
            5'd6: tx_byte = 8'h07;
            5'd7: tx_byte = 8'h00;
            5'd8: tx_byte = resp_lenl;
            5'd9: tx_byte = conf;
            default: begin
                if (rel < {2'b00, n_data}) begin
                    case (rel[1:0])
                        2'd0:    tx_byte = data[31:24];
                        2'd1:    tx_byte = data[23:16];
                        2'd2:    tx_byte = data[15:8];
                        default: tx_byte = data[7:0];
                    endcase
                end else if (rel == {2'b00, n_data}) begin
                    tx_byte = resp_sum[15:8];
                end else begin
                    tx_byte = resp_sum[7:0];
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Packet datapath: checksum, payload count, timeout counter, response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= 16'h0000;
            pay_left  <= 16'h0000;
            lenh      <= 8'h00;
            sumh      <= 8'h00;
            instr     <= 8'h00;
            first     <= 1'b0;
            tmo_cnt   <= 24'd0;
            conf      <= 8'h00;
            data      <= 32'h0;
            n_data    <= 3'd0;
            tx_idx    <= 5'd0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pkt_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            pkt_err   <= err_n;
            if (!rx_state || rx_valid) tmo_cnt <= 24'd0;
            else                       tmo_cnt <= tmo_cnt + 24'd1;
            if (rx_valid) begin
                case (state)
                    PID:  sum <= {8'h00, rx_data};
                    LENH: begin
                        lenh <= rx_data;
                        sum  <= sum + {8'h00, rx_data};
                    end
                    LENL: begin
                        pay_left <= len_w - 16'd2;
                        first    <= 1'b1;
                        sum      <= sum + {8'h00, rx_data};
                    end
                    PAYLOAD: begin
                        sum      <= sum + {8'h00, rx_data};
                        pay_left <= pay_left - 16'd1;
                        first    <= 1'b0;
                        if (first) instr <= rx_data;
                    end
                    SUMH: sumh <= rx_data;
                    SUML: begin
                        tx_idx <= 5'd0;
                        data   <= 32'h0;
                        n_data <= 3'd0;
                        if (sum_ok) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= instr;
                            case (instr)
                                8'h01: conf <= finger_present ? 8'h00 : 8'h02;
                                8'h02, 8'h05, 8'h06: conf <= 8'h00;
                                8'h03: begin
                                    conf   <= 8'h00;
                                    data   <= {match_score, 16'h0000};
                                    n_data <= 3'd2;
                                end
                                8'h04: begin
                                    conf   <= 8'h00;
                                    data   <= {match_page, match_score};
                                    n_data <= 3'd4;
                                end
                                default: conf <= 8'h1A;
                            endcase
                        end else begin
                            conf <= 8'h01;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == RESP && tx_ready) tx_idx <= tx_idx + 5'd1;
        end
    end

endmodule
